// File: rtl/umi_pkg.sv
// Shared UMI widths, end-of-message bit position and flattened-slice helpers.
// Consumed by umi_arbiter and its interface.
package umi_pkg;

    localparam int UMI_AW     = 64;
    localparam int UMI_CW     = 32;
    localparam int UMI_UW     = 256;
    localparam int UMI_EOMBIT = 22;

    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

    function automatic int slice_hi(input int idx, input int w);
        return idx * w + w - 1;
    endfunction

endpackage

// File: rtl/umi_arbiter_if.sv
// Handshake bundle between N UMI requesters, the arbiter and one UMI output.
// slave = arbiter side, master = requester/sink side.
interface umi_arbiter_if
    import umi_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = UMI_AW,
    parameter int CW = UMI_CW,
    parameter int UW = UMI_UW
) ();

    logic [N-1:0]    arb_mask;
    logic [N-1:0]    umi_in_valid;
    logic [N*CW-1:0] umi_in_cmd;
    logic [N*AW-1:0] umi_in_dst_addr;
    logic [N*AW-1:0] umi_in_src_addr;
    logic [N*UW-1:0] umi_in_payload;
    logic [N-1:0]    umi_in_ready;

    logic            umi_out_valid;
    logic [CW-1:0]   umi_out_cmd;
    logic [AW-1:0]   umi_out_dst_addr;
    logic [AW-1:0]   umi_out_src_addr;
    logic [UW-1:0]   umi_out_payload;
    logic            umi_out_ready;
    logic [N-1:0]    arb_owner;

    modport slave (
        input  arb_mask, umi_in_valid, umi_in_cmd,
        input  umi_in_dst_addr, umi_in_src_addr, umi_in_payload,
        output umi_in_ready,
        output umi_out_valid, umi_out_cmd, umi_out_dst_addr,
        output umi_out_src_addr, umi_out_payload, arb_owner,
        input  umi_out_ready
    );

    modport master (
        output arb_mask, umi_in_valid, umi_in_cmd,
        output umi_in_dst_addr, umi_in_src_addr, umi_in_payload,
        input  umi_in_ready,
        input  umi_out_valid, umi_out_cmd, umi_out_dst_addr,
        input  umi_out_src_addr, umi_out_payload, arb_owner,
        output umi_out_ready
    );

endinterface

// File: rtl/umi_arb_rr.sv
// N-wide rotating-priority one-hot encoder: first set req bit at or above
// ptr, wrapping past N-1 to 0.
module umi_arb_rr #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/umi_arbiter.sv
// Round-robin UMI arbiter with a single registered output stage.
// Define UMI_ARB_LOCK_EN to hold the grant across a multi-beat message.
module umi_arbiter
    import umi_pkg::*;
#(
    parameter int N      = 4,
    parameter int AW     = UMI_AW,
    parameter int CW     = UMI_CW,
    parameter int UW     = UMI_UW,
    parameter int EOMBIT = UMI_EOMBIT
) (
    input logic          umi_clk,
    input logic          umi_nreset,
    umi_arbiter_if.slave u
);

    localparam int PW = $clog2(N);

    if (N < 2 || N > 16 || EOMBIT >= CW) begin : g_param_err
        $error("umi_arbiter: parameter out of range");
    end

    logic [PW-1:0] ptr;
    logic [PW-1:0] sel;
    logic [PW-1:0] ptr_nxt;
    logic [N-1:0]  req;
    logic [N-1:0]  rr_grant;
    logic [N-1:0]  grant;
    logic          load;
    logic          accept;

    logic          out_valid;
    logic [CW-1:0] out_cmd;
    logic [AW-1:0] out_dst;
    logic [AW-1:0] out_src;
    logic [UW-1:0] out_pay;
    logic [N-1:0]  owner;

    logic [CW-1:0] mux_cmd;
    logic [AW-1:0] mux_dst;
    logic [AW-1:0] mux_src;
    logic [UW-1:0] mux_pay;

    assign load = ~out_valid | u.umi_out_ready;
    assign req  = u.umi_in_valid & ~u.arb_mask;

    umi_arb_rr #(.N(N)) u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (rr_grant)
    );

`ifdef UMI_ARB_LOCK_EN
    logic          locked;
    logic [PW-1:0] lock_idx;

    // Mask is ignored for the lock owner so a message is never split.
    always_comb begin
        grant = rr_grant;
        if (locked) begin
            grant           = '0;
            grant[lock_idx] = u.umi_in_valid[lock_idx];
        end
    end
`else
    assign grant = rr_grant;
`endif

    assign u.umi_in_ready = grant & {N{load & umi_nreset}};
    assign accept         = |(u.umi_in_ready & u.umi_in_valid);

    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) sel = PW'(i);
        end
    end

    assign ptr_nxt = (sel == PW'(N - 1)) ? '0 : sel + 1'b1;

    always_comb begin
        mux_cmd = u.umi_in_cmd[slice_lo(int'(sel), CW) +: CW];
        mux_dst = u.umi_in_dst_addr[slice_lo(int'(sel), AW) +: AW];
        mux_src = u.umi_in_src_addr[slice_lo(int'(sel), AW) +: AW];
        mux_pay = u.umi_in_payload[slice_lo(int'(sel), UW) +: UW];
    end

    always_ff @(posedge umi_clk or negedge umi_nreset) begin
        if (!umi_nreset) begin
            out_valid <= 1'b0;
            out_cmd   <= '0;
            out_dst   <= '0;
            out_src   <= '0;
            out_pay   <= '0;
            owner     <= '0;
            ptr       <= '0;
`ifdef UMI_ARB_LOCK_EN
            locked    <= 1'b0;
            lock_idx  <= '0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            out_cmd   <= mux_cmd;
            out_dst   <= mux_dst;
            out_src   <= mux_src;
            out_pay   <= mux_pay;
            owner     <= grant;
`ifdef UMI_ARB_LOCK_EN
            if (!mux_cmd[EOMBIT]) begin
                locked   <= 1'b1;
                lock_idx <= sel;
            end else begin
                locked   <= 1'b0;
                ptr      <= ptr_nxt;
            end
`else
            ptr       <= ptr_nxt;
`endif
        end else if (u.umi_out_ready) begin
            out_valid <= 1'b0;
            owner     <= '0;
        end
    end

    assign u.umi_out_valid    = out_valid;
    assign u.umi_out_cmd      = out_cmd;
    assign u.umi_out_dst_addr = out_dst;
    assign u.umi_out_src_addr = out_src;
    assign u.umi_out_payload  = out_pay;
    assign u.arb_owner        = owner;

endmodule

// File: tb/tb_umi_arbiter.sv
// Scoreboard bench for umi_arbiter: directed sources feed per-input queues,
// expected beats are queued up front and checked by a separate monitor.
module tb_umi_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int CW = 32;
    localparam int UW = 256;

    typedef struct {
        logic [N-1:0] owner;
        logic [31:0]  cmd;
        logic [31:0]  pay;
    } beat_t;

    logic clk;
    logic rst_n;

    int compared;
    int mismatched;

    beat_t src_q[N][$];
    beat_t exp_q[$];

    umi_arbiter_if #(.N(N), .AW(AW), .CW(CW), .UW(UW)) bus ();

    umi_arbiter #(.N(N), .AW(AW), .CW(CW), .UW(UW)) dut (
        .umi_clk    (clk),
        .umi_nreset (rst_n),
        .u          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic beat_t mk(input int i, input int s, input bit eom);
        beat_t b;
        b.owner = N'(1) << i;
        b.cmd   = 32'h0000_0010 + 32'(i) + (32'(eom) << 22);
        b.pay   = 32'hA000_0000 + 32'(i) * 32'h100 + 32'(s);
        return b;
    endfunction

    task automatic push(input int i, input int s, input bit eom);
        src_q[i].push_back(mk(i, s, eom));
    endtask

    task automatic expect_beat(input int i, input int s, input bit eom);
        exp_q.push_back(mk(i, s, eom));
    endtask

    task automatic drive();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                bus.umi_in_valid[i] = 1'b1;
                bus.umi_in_cmd[i*CW +: CW]      = b.cmd;
                bus.umi_in_dst_addr[i*AW +: AW] = 64'(b.pay) + 64'd1;
                bus.umi_in_src_addr[i*AW +: AW] = 64'(b.pay) + 64'd2;
                bus.umi_in_payload[i*UW +: UW]  = 256'(b.pay);
            end else begin
                bus.umi_in_valid[i] = 1'b0;
                bus.umi_in_cmd[i*CW +: CW]      = '0;
                bus.umi_in_dst_addr[i*AW +: AW] = '0;
                bus.umi_in_src_addr[i*AW +: AW] = '0;
                bus.umi_in_payload[i*UW +: UW]  = '0;
            end
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
    endtask

    // One clock: handshakes are sampled on the falling edge, sources
    // advance just after the rising edge.
    task automatic step();
        logic [N-1:0] fire;
        @(negedge clk);
        fire = bus.umi_in_valid & bus.umi_in_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fire[i]) void'(src_q[i].pop_front());
        end
        drive();
    endtask

    task automatic chk(input string name, input logic [255:0] got,
                       input logic [255:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        clear_all();
        bus.arb_mask      = '0;
        bus.umi_out_ready = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (rst_n && bus.umi_out_valid && bus.umi_out_ready) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL beat: got owner %b pay %0h want none",
                         bus.arb_owner, bus.umi_out_payload);
            end else begin
                e = exp_q.pop_front();
                if (bus.arb_owner !== e.owner ||
                    bus.umi_out_cmd !== e.cmd ||
                    bus.umi_out_payload !== 256'(e.pay) ||
                    bus.umi_out_dst_addr !== 64'(e.pay) + 64'd1 ||
                    bus.umi_out_src_addr !== 64'(e.pay) + 64'd2) begin
                    mismatched++;
                    $display("FAIL beat: got owner %b cmd %0h pay %0h want owner %b cmd %0h pay %0h",
                             bus.arb_owner, bus.umi_out_cmd,
                             bus.umi_out_payload, e.owner, e.cmd, e.pay);
                end
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        bus.arb_mask      = '0;
        bus.umi_out_ready = 1'b1;
        clear_all();
        push(0, 0, 1'b1);
        drive();
        #3;
        chk("rst_valid", 256'(bus.umi_out_valid), 256'(0));
        chk("rst_owner", 256'(bus.arb_owner), 256'(0));
        chk("rst_ready", 256'(bus.umi_in_ready), 256'(0));
        chk("rst_pay", bus.umi_out_payload, 256'(0));

        // Full load: owners rotate 0..3 at one beat per cycle.
        reset_dut();
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < N; i++) begin
                push(i, s, 1'b1);
                expect_beat(i, s, 1'b1);
            end
        end
        drive();
        repeat (13) step();
        chk("full_drain", 256'(exp_q.size()), 256'(0));
        chk("full_idle", 256'(bus.umi_out_valid), 256'(0));

        // Backpressure with input 2 holding the output register.
        reset_dut();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < N; i++) begin
                push(i, s, 1'b1);
                expect_beat(i, s, 1'b1);
            end
        end
        drive();
        repeat (3) step();
        bus.umi_out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_owner", 256'(bus.arb_owner), 256'(4'b0100));
            chk("bp_pay", bus.umi_out_payload, 256'(mk(2, 0, 1'b1).pay));
            chk("bp_ready", 256'(bus.umi_in_ready), 256'(0));
        end
        bus.umi_out_ready = 1'b1;
        #1;
        chk("bp_next", 256'(bus.umi_in_ready), 256'(4'b1000));
        repeat (8) step();
        chk("bp_drain", 256'(exp_q.size()), 256'(0));

        // Single requester streams back-to-back.
        reset_dut();
        for (int s = 0; s < 8; s++) begin
            push(2, s, 1'b1);
            expect_beat(2, s, 1'b1);
        end
        drive();
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("single_rdy", 256'(bus.umi_in_ready), 256'(4'b0100));
            step();
        end
        repeat (2) step();
        chk("single_drain", 256'(exp_q.size()), 256'(0));

        // Masked requester 1 is skipped, then served once unmasked.
        reset_dut();
        bus.arb_mask = 4'b0010;
        push(0, 0, 1'b1); push(0, 1, 1'b1);
        push(1, 0, 1'b1); push(1, 1, 1'b1);
        push(2, 0, 1'b1); push(3, 0, 1'b1);
        expect_beat(0, 0, 1'b1); expect_beat(2, 0, 1'b1);
        expect_beat(3, 0, 1'b1); expect_beat(0, 1, 1'b1);
        drive();
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("mask_rdy1", 256'(bus.umi_in_ready[1]), 256'(0));
            step();
        end
        chk("mask_drain", 256'(exp_q.size()), 256'(0));
        bus.arb_mask = '0;
        expect_beat(1, 0, 1'b1); expect_beat(1, 1, 1'b1);
        repeat (4) step();
        chk("unmask_drain", 256'(exp_q.size()), 256'(0));

        // Multi-beat message from input 0 racing input 1.
        reset_dut();
        push(0, 0, 1'b0); push(0, 1, 1'b0); push(0, 2, 1'b1);
        push(1, 0, 1'b1); push(1, 1, 1'b1);
`ifdef UMI_ARB_LOCK_EN
        expect_beat(0, 0, 1'b0); expect_beat(0, 1, 1'b0);
        expect_beat(0, 2, 1'b1); expect_beat(1, 0, 1'b1);
        expect_beat(1, 1, 1'b1);
`else
        expect_beat(0, 0, 1'b0); expect_beat(1, 0, 1'b1);
        expect_beat(0, 1, 1'b0); expect_beat(1, 1, 1'b1);
        expect_beat(0, 2, 1'b1);
`endif
        drive();
        repeat (8) step();
        chk("msg_drain", 256'(exp_q.size()), 256'(0));

        // Reset while the output is stalled drops the beat.
        reset_dut();
        bus.umi_out_ready = 1'b0;
        push(2, 0, 1'b1); push(3, 0, 1'b1);
        drive();
        step();
        chk("stall_valid", 256'(bus.umi_out_valid), 256'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 256'(bus.umi_out_valid), 256'(0));
        chk("mid_rst_owner", 256'(bus.arb_owner), 256'(0));
        chk("mid_rst_pay", bus.umi_out_payload, 256'(0));
        chk("mid_rst_ready", 256'(bus.umi_in_ready), 256'(0));
        clear_all();
        for (int i = 0; i < N; i++) begin
            push(i, 1, 1'b1);
            expect_beat(i, 1, 1'b1);
        end
        bus.umi_out_ready = 1'b1;
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_first", 256'(bus.umi_in_ready), 256'(4'b0001));
        repeat (6) step();
        chk("rst_drain", 256'(exp_q.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
